// File: rtl/wave_pkg.sv
// Shared definitions for the waveform lookup blocks: the reader FSM state
// encoding and the default datapath widths.
package wave_pkg;

    localparam int WAVE_PHASE_WIDTH = 24;
    localparam int WAVE_ADDR_WIDTH  = 8;
    localparam int WAVE_DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } wave_state_e;

endpackage

// File: rtl/phase_accumulator.sv
// N-bit phase accumulator with synchronous clear; exposes the table address
// slice of the post-increment phase so a fetch can start on the tick edge.
module phase_accumulator
    import wave_pkg::*;
#(
    parameter int PHASE_WIDTH = WAVE_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = WAVE_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   adv_i,
    input  logic [PHASE_WIDTH-1:0] tune_word_i,
    output logic [ADDR_WIDTH-1:0]  addr_next_o
);

    logic [PHASE_WIDTH-1:0] phase_q;
    logic [PHASE_WIDTH-1:0] phase_d;
    logic [PHASE_WIDTH-1:0] phase_sum_s;

    // Next phase: clear wins over advance; the carry out of the MSB is dropped.
    always_comb begin
        phase_sum_s = phase_q + tune_word_i;
        if (clr_i) begin
            phase_d = {PHASE_WIDTH{1'b0}};
        end else if (adv_i) begin
            phase_d = phase_sum_s;
        end else begin
            phase_d = phase_q;
        end
    end

    assign addr_next_o = phase_sum_s[PHASE_WIDTH-1 -: ADDR_WIDTH];

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= {PHASE_WIDTH{1'b0}};
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/wave_phase_reader.sv
// Phase-driven table reader: advances phase on each accepted tick, fetches the
// table entry over its one-cycle read latency and offers it on valid/ready.
module wave_phase_reader
    import wave_pkg::*;
#(
    parameter int PHASE_WIDTH = WAVE_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = WAVE_ADDR_WIDTH,
    parameter int DATA_WIDTH  = WAVE_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   sample_tick,
    input  logic [PHASE_WIDTH-1:0] tune_word,
    input  logic                   phase_reset,
    output logic [ADDR_WIDTH-1:0]  addr_r,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  sample,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun
);

    wave_state_e             state_q;
    wave_state_e             state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic [DATA_WIDTH-1:0]   sample_d;
    logic                    valid_q;
    logic                    valid_d;
    logic                    overrun_q;
    logic                    overrun_d;
    logic                    tick_acc_s;
    logic [ADDR_WIDTH-1:0]   addr_next_s;

    assign tick_acc_s = sample_tick & en & ~phase_reset;

    phase_accumulator #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_phase_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (phase_reset),
        .adv_i       (tick_acc_s),
        .tune_word_i (tune_word),
        .addr_next_o (addr_next_s)
    );

    // Next-state and output logic; phase_reset overrides every state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (phase_reset) begin
            state_d   = IDLE;
            addr_d    = {ADDR_WIDTH{1'b0}};
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_acc_s) begin
                        addr_d  = addr_next_s;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    state_d = WAIT;
                    if (tick_acc_s) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
                WAIT: begin
                    sample_d = din;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                    if (tick_acc_s) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
                HOLD: begin
                    // A tick landing on the handshake edge chains straight into the next fetch.
                    if (valid_q && sample_ready) begin
                        valid_d = 1'b0;
                        if (tick_acc_s) begin
                            addr_d  = addr_next_s;
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (tick_acc_s) begin
                        overrun_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, address, capture and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            sample_q  <= {DATA_WIDTH{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign addr_r       = addr_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_wave_phase_reader.sv
// Directed bench for wave_phase_reader paired with a registered triangle table.
module tb_wave_phase_reader;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sample_tick;
    logic [23:0] tune_word;
    logic        phase_reset;
    logic [7:0]  addr_r;
    logic [15:0] din;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    wave_phase_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_tick  (sample_tick),
        .tune_word    (tune_word),
        .phase_reset  (phase_reset),
        .addr_r       (addr_r),
        .din          (din),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Triangle table: rises 0x8000 -> 0x7E00 over the first half, falls back after.
    function automatic logic [15:0] tri_val(input logic [7:0] a);
        logic [15:0] m;
        m = a[7] ? {8'd0, ~a} : {8'd0, a};
        return 16'h8000 + (m << 9);
    endfunction

    always_ff @(posedge clk) din <= tri_val(addr_r);

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic pulse_phase_reset();
        phase_reset = 1'b1;
        step(1);
        phase_reset = 1'b0;
    endtask

    // One complete fetch with ready high, including the 2-cycle latency checks.
    task automatic run_fetch(input string tag, input logic [7:0] ea, input logic [15:0] es);
        do_tick();
        check({tag, "_addr"}, addr_r, ea);
        check({tag, "_v0"}, sample_valid, 1'b0);
        step(1);
        check({tag, "_v1"}, sample_valid, 1'b0);
        step(1);
        check({tag, "_v2"}, sample_valid, 1'b1);
        check({tag, "_smp"}, sample, es);
        step(1);
        check({tag, "_hs"}, sample_valid, 1'b0);
        step(4);
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b1;
        sample_tick  = 1'b0;
        tune_word    = 24'h000000;
        phase_reset  = 1'b0;
        sample_ready = 1'b1;
        step(2);
        check("rst_addr", addr_r, 8'h00);
        check("rst_sample", sample, 16'h0000);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Basic stepping
        tune_word = 24'h010000;
        run_fetch("s1", 8'h01, 16'h8200);
        run_fetch("s2", 8'h02, 16'h8400);
        run_fetch("s3", 8'h03, 16'h8600);

        // Half-cycle tuning
        pulse_phase_reset();
        check("pr_addr", addr_r, 8'h00);
        tune_word = 24'h800000;
        run_fetch("h1", 8'h80, 16'h7E00);
        run_fetch("h2", 8'h00, 16'h8000);
        run_fetch("h3", 8'h80, 16'h7E00);

        // Wrap across 2^24
        pulse_phase_reset();
        tune_word = 24'hFF0000;
        run_fetch("w1", 8'hFF, 16'h8000);
        tune_word = 24'h020000;
        run_fetch("w2", 8'h01, 16'h8200);
        check("w_ovr", overrun, 1'b0);

        // Backpressure with two extra ticks
        pulse_phase_reset();
        tune_word    = 24'h010000;
        sample_ready = 1'b0;
        do_tick();
        check("bp_addr", addr_r, 8'h01);
        step(2);
        check("bp_valid", sample_valid, 1'b1);
        check("bp_smp", sample, 16'h8200);
        do_tick();
        check("bp_ovr", overrun, 1'b1);
        step(2);
        do_tick();
        step(3);
        check("bp_hold_smp", sample, 16'h8200);
        check("bp_hold_valid", sample_valid, 1'b1);
        check("bp_hold_addr", addr_r, 8'h01);
        sample_ready = 1'b1;
        step(1);
        check("bp_hs_valid", sample_valid, 1'b0);
        check("bp_sticky", overrun, 1'b1);
        step(2);
        run_fetch("bp_next", 8'h04, 16'h8800);

        // Tick coincident with handshake
        pulse_phase_reset();
        check("co_clr_ovr", overrun, 1'b0);
        sample_ready = 1'b0;
        do_tick();
        step(2);
        check("co_valid", sample_valid, 1'b1);
        step(1);
        sample_ready = 1'b1;
        do_tick();
        check("co_addr", addr_r, 8'h02);
        check("co_valid0", sample_valid, 1'b0);
        check("co_ovr", overrun, 1'b0);
        step(2);
        check("co_valid1", sample_valid, 1'b1);
        check("co_smp", sample, 16'h8400);
        step(4);

        // phase_reset with a simultaneous tick while in WAIT
        do_tick();
        check("pw_addr", addr_r, 8'h03);
        do_tick();
        check("pw_ovr_set", overrun, 1'b1);
        phase_reset = 1'b1;
        sample_tick = 1'b1;
        step(1);
        phase_reset = 1'b0;
        sample_tick = 1'b0;
        check("pw_valid", sample_valid, 1'b0);
        check("pw_addr0", addr_r, 8'h00);
        check("pw_ovr", overrun, 1'b0);
        check("pw_smp_kept", sample, 16'h8400);
        step(3);
        check("pw_idle_valid", sample_valid, 1'b0);
        run_fetch("pw_next", 8'h01, 16'h8200);

        // Asynchronous reset while holding a sample
        sample_ready = 1'b0;
        do_tick();
        step(2);
        check("ar_valid_pre", sample_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_addr", addr_r, 8'h00);
        check("ar_smp", sample, 16'h0000);
        check("ar_valid", sample_valid, 1'b0);
        check("ar_ovr", overrun, 1'b0);
        #2;
        rst_n        = 1'b1;
        sample_ready = 1'b1;
        step(2);
        run_fetch("ar_next", 8'h01, 16'h8200);

        // Enable: in-flight fetch completes, new ticks ignored
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        en          = 1'b0;
        check("en_addr", addr_r, 8'h02);
        step(2);
        check("en_valid", sample_valid, 1'b1);
        check("en_smp", sample, 16'h8400);
        step(1);
        do_tick();
        step(3);
        check("en_blk_valid", sample_valid, 1'b0);
        check("en_blk_addr", addr_r, 8'h02);
        en = 1'b1;
        run_fetch("en_next", 8'h03, 16'h8600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wave_phase_reader.md
# wave_phase_reader

Phase-accumulator address generator and sample reader for the synth's single-cycle-registered waveform lookup blocks (triangle, saw, sine tables). On each accepted sample-rate tick it advances an N-bit phase by a tuning word, drives the table address from the phase MSBs, captures the table output after its one-cycle read latency, and presents the sample downstream on a valid/ready handshake. It sits between the sample-rate timebase and the voice mixer, one instance per oscillator.

## Interface
- PHASE_WIDTH, 24, phase accumulator width; pitch resolution is f_tick/2^PHASE_WIDTH
- ADDR_WIDTH, 8, table address width; must be ≤ PHASE_WIDTH
- DATA_WIDTH, 16, sample width, two's complement
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  oscillator enable; when low, ticks are ignored
- sample_tick  in  1  single-cycle sample-rate strobe
- tune_word  in  PHASE_WIDTH  phase increment per tick, unsigned; sampled on the tick cycle
- phase_reset  in  1  synchronous phase/transaction clear
- addr_r  out  ADDR_WIDTH  table read address, registered
- din  in  DATA_WIDTH  table data; valid from the second edge after addr_r changes
- sample  out  DATA_WIDTH  captured sample, stable while sample_valid high
- sample_valid  out  1  downstream valid
- sample_ready  in  1  downstream ready
- overrun  out  1  sticky: a tick arrived while a fetch/hold was still pending

## Operation
- Reset (rst_n low): phase=0, addr_r=0, sample=0, sample_valid=0, overrun=0, state IDLE.
- Accepted tick = sample_tick & en & ~phase_reset. On every accepted tick, phase <= phase + tune_word (mod 2^PHASE_WIDTH), regardless of FSM state, so pitch never drifts.
- addr_r <= upper ADDR_WIDTH bits of the post-increment phase, only when a fetch starts.
- FSM states: IDLE, FETCH, WAIT, HOLD.
  - IDLE: accepted tick -> load addr_r, go FETCH.
  - FETCH: table registers addr_r this edge; go WAIT.
  - WAIT: capture din into sample, set sample_valid, go HOLD.
  - HOLD: on sample_valid & sample_ready: clear sample_valid; if an accepted tick occurs in the same cycle, load addr_r and go FETCH, else go IDLE.
- Accepted tick in FETCH, WAIT, or HOLD without handshake: fetch is skipped, phase still advances, overrun <= 1.
- phase_reset (highest priority): phase=0, addr_r=0, sample_valid=0, overrun=0, state IDLE; sample keeps its value. A tick in the same cycle is discarded.
- en low mid-transaction: the current fetch/hold completes normally; only new ticks are blocked.
- sample does not change while sample_valid is high (AXI-style stability).

## Timing
- Tick sampled at edge E0 -> addr_r valid after E0 -> table registers at E1 -> sample/sample_valid valid after E2. Latency tick-to-valid is 2 cycles; first possible handshake is at edge E3.
- Maximum sustained rate with sample_ready tied high: one sample per 3 clocks (tick period ≥ 3).
- Phase wrap: carry out of the MSB is dropped; addr_r wraps from 2^ADDR_WIDTH−1 to 0 with no glitch or extra cycle.
- sample_ready has no combinational path to any output.

## Structure
- Shared package wave_pkg: the FSM state enum (IDLE, FETCH, WAIT, HOLD) and default width constants (PHASE_WIDTH, ADDR_WIDTH, DATA_WIDTH) reused by all waveform tables.
- One sub-module: phase_accumulator (phase register, add, wrap, synchronous clear, MSB address slice). FSM, capture register, and overrun flag stay in the top module.
- Bench pairs this block with the triangle table instance.

## Test plan
- Reset then tune_word=24'h010000, ticks every 8 cycles, ready=1 -> addr_r 0x01, 0x02, 0x03; samples 0x8200, 0x8400, 0x8600; valid asserted 2 cycles after each tick.
- tune_word=24'h800000 -> addr_r alternates 0x80, 0x00; samples 0x7E00 then 0x8000.
- Phase wrap: phase preloaded near 2^24 via ticks with tune_word=24'hFF0000 then 24'h020000 -> addr_r 0xFF then 0x01; no missing sample.
- Backpressure: ready=0 for 10 cycles while 2 further ticks arrive -> sample held stable, overrun=1, phase advanced by 3×tune_word; ready=1 -> one handshake, then IDLE.
- Tick coincident with handshake in HOLD -> addr_r updates that edge, FSM goes FETCH directly, overrun stays 0.
- phase_reset asserted during WAIT with simultaneous tick -> next cycle sample_valid=0, addr_r=0, overrun=0, state IDLE; async rst_n pulse mid-HOLD -> all outputs zero immediately.
